stepper_motion_ctrl: RTL and testbench

Motion-profile controller that drives the stepper_core control inputs (en, dir, step_delay) and consumes its coil_out.
- Accepts a move command (step count, direction, cruise speed) over a valid/ready handshake.
- Generates a symmetric trapezoidal speed ramp (accelerate, cruise, decelerate), counts completed half-steps from coil transitions, and tracks absolute position.
- Sits between the AXI register interface and stepper_core.

---
 rtl/stepper_motion_ctrl_if.sv | 19 +
 rtl/stepper_motion_ctrl.sv | 147 ++++++++++++++
 tb/tb_stepper_motion_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_motion_ctrl_if.sv
// Move-command handshake between the register block (master) and the
// motion controller (slave).
interface stepper_motion_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps;
  logic        cmd_dir;
  logic [31:0] cmd_min_delay;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_min_delay,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_min_delay,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_motion_ctrl.sv
// Trapezoidal motion-profile controller: drives stepper_core en/dir/step_delay
// and counts half-steps from the fed-back coil pattern.
module stepper_motion_ctrl #(
  parameter logic [31:0] START_DELAY     = 32'd100000,
  parameter logic [31:0] ACCEL_STEP      = 32'd2000,
  parameter logic [31:0] MIN_DELAY_FLOOR = 32'd4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  stepper_motion_ctrl_if.slave        cmd,
  input  logic                        abort,
  input  logic [3:0]                  coil_in,
  output logic                        motor_en,
  output logic                        motor_dir,
  output logic [31:0]                 step_delay,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [31:0]                 position
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_steps;
  logic [31:0] r_done_cnt;
  logic [31:0] r_ramp;
  logic [31:0] r_eff_min;
  logic [31:0] r_delay;
  logic [31:0] r_pos;
  logic        r_dir;
  logic        r_aborted;
  logic [3:0]  r_coil_prev;

  logic        w_ready;
  logic        w_accept;
  logic        w_step;
  logic [31:0] w_done_next;
  logic [31:0] w_remaining;
  logic [31:0] w_lo;
  logic [31:0] w_eff;
  logic [32:0] w_inc;
  logic [31:0] w_dec_delay;
  logic [31:0] w_acc_delay;

  // abort in IDLE deliberately suppresses command acceptance
  assign w_accept    = (r_state == IDLE) && cmd.cmd_valid && !abort;
  assign w_step      = (r_state == RUN) && (coil_in != r_coil_prev) &&
                       (r_coil_prev != 4'b0000) && (coil_in != 4'b0000);
  assign w_done_next = r_done_cnt + 32'd1;
  assign w_remaining = r_steps - w_done_next;

  assign w_lo  = (cmd.cmd_min_delay < MIN_DELAY_FLOOR) ? MIN_DELAY_FLOOR : cmd.cmd_min_delay;
  assign w_eff = (w_lo > START_DELAY) ? START_DELAY : w_lo;

  // decel saturates at START_DELAY; accel clamps at eff_min without underflow
  assign w_inc       = {1'b0, r_delay} + {1'b0, ACCEL_STEP};
  assign w_dec_delay = (w_inc > {1'b0, START_DELAY}) ? START_DELAY : w_inc[31:0];
  assign w_acc_delay = ((r_delay < ACCEL_STEP) || ((r_delay - ACCEL_STEP) < r_eff_min)) ?
                       r_eff_min : (r_delay - ACCEL_STEP);

  assign cmd.cmd_ready = w_ready;
  assign motor_dir     = r_dir;
  assign step_delay    = r_delay;
  assign position      = r_pos;
  assign aborted       = done && r_aborted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    motor_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept) w_next = (cmd.cmd_steps == 32'd0) ? FINISH : RUN;
      end
      RUN: begin
        motor_en = 1'b1;
        busy     = 1'b1;
        if (abort || (w_step && (w_remaining == 32'd0))) w_next = FINISH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steps     <= '0;
      r_done_cnt  <= '0;
      r_ramp      <= '0;
      r_eff_min   <= '0;
      r_delay     <= START_DELAY;
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_aborted   <= 1'b0;
      r_coil_prev <= '0;
    end else begin
      r_coil_prev <= coil_in;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_steps    <= cmd.cmd_steps;
            r_dir      <= cmd.cmd_dir;
            r_eff_min  <= w_eff;
            r_delay    <= START_DELAY;
            r_ramp     <= '0;
            r_done_cnt <= '0;
            r_aborted  <= 1'b0;
          end
        end
        RUN: begin
          if (w_step) begin
            r_done_cnt <= w_done_next;
            r_pos      <= r_dir ? (r_pos - 32'd1) : (r_pos + 32'd1);
          end
          // a step coinciding with abort still moves position but not the ramp
          if (abort) begin
            r_aborted <= 1'b1;
          end else if (w_step && (w_remaining != 32'd0)) begin
            if (w_remaining <= r_ramp) begin
              r_delay <= w_dec_delay;
              r_ramp  <= r_ramp - 32'd1;
            end else if (r_delay > r_eff_min) begin
              r_delay <= w_acc_delay;
              r_ramp  <= r_ramp + 32'd1;
            end
          end
        end
        FINISH: r_delay <= START_DELAY;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Directed bench for stepper_motion_ctrl: table of single-cycle vectors plus
// hand-written move sequences; the bench drives coil_in in place of stepper_core.
`timescale 1ns/1ps
module tb_stepper_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abortIn = 1'b0;
  logic [3:0]  coilIn = 4'b0000;
  logic        motorEn;
  logic        motorDir;
  logic [31:0] stepDelay;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] position;

  int total = 0;
  int bad   = 0;
  int seqIdx = 0;
  logic [3:0] halfSeq [8];

  typedef struct {
    logic        valid;
    logic [31:0] steps;
    logic        dir;
    logic [31:0] minDelay;
    logic        abortV;
    logic [3:0]  coil;
    logic [5:0]  expFlags;
    logic [31:0] expDelay;
    logic [31:0] expPos;
  } vec_t;

  vec_t vecs[$];

  stepper_motion_ctrl_if cmdIf();

  stepper_motion_ctrl #(
    .START_DELAY    (32'd1000),
    .ACCEL_STEP     (32'd100),
    .MIN_DELAY_FLOOR(32'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmdIf),
    .abort     (abortIn),
    .coil_in   (coilIn),
    .motor_en  (motorEn),
    .motor_dir (motorDir),
    .step_delay(stepDelay),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .position  (position)
  );

  always #5 clk = ~clk;

  // flag order: {cmd_ready, motor_en, motor_dir, busy, done, aborted}
  function automatic logic [5:0] flags();
    return {cmdIf.cmd_ready, motorEn, motorDir, busy, done, aborted};
  endfunction

  function automatic logic [3:0] advanceCoil();
    seqIdx = (seqIdx + 1) % 8;
    return halfSeq[seqIdx];
  endfunction

  function automatic logic [31:0] expA(int k);
    if (k <= 3)  return 32'(1000 - 100 * k);
    if (k <= 16) return 32'd700;
    return 32'(700 + 100 * (k - 16));
  endfunction

  function automatic logic [31:0] expC(int k);
    if (k <= 9)  return 32'(1000 - 100 * k);
    if (k <= 19) return 32'd4;
    if (k <= 28) return 32'(4 + 100 * (k - 19));
    return 32'd1000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [5:0] f, input logic [31:0] d, input logic [31:0] p);
    checkOutput($sformatf("%s/flags", tag), 32'(flags()), 32'(f));
    checkOutput($sformatf("%s/delay", tag), stepDelay, d);
    checkOutput($sformatf("%s/pos", tag), position, p);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic applyStimulus(input logic valid, input logic [31:0] steps, input logic dir,
                               input logic [31:0] minDelay, input logic abortV, input logic [3:0] coil);
    cmdIf.cmd_valid     = valid;
    cmdIf.cmd_steps     = steps;
    cmdIf.cmd_dir       = dir;
    cmdIf.cmd_min_delay = minDelay;
    abortIn             = abortV;
    coilIn              = coil;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic addVec(input logic valid, input logic [31:0] steps, input logic dir,
                        input logic [31:0] minDelay, input logic abortV, input logic [3:0] coil,
                        input logic [5:0] f, input logic [31:0] d, input logic [31:0] p);
    vec_t v;
    v.valid = valid; v.steps = steps; v.dir = dir; v.minDelay = minDelay;
    v.abortV = abortV; v.coil = coil; v.expFlags = f; v.expDelay = d; v.expPos = p;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_steps = '0;
    cmdIf.cmd_dir = 1'b0;
    cmdIf.cmd_min_delay = '0;
    abortIn = 1'b0;
    coilIn = 4'b0000;
    seqIdx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000ns");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    halfSeq = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_steps = '0;
    cmdIf.cmd_dir = 1'b0;
    cmdIf.cmd_min_delay = '0;
    repeat (2) @(negedge clk);
    checkState("reset", 6'b100000, 32'd1000, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle vectors: idle, abort-blocked accept, zero-step move, 4-step CW move
    addVec(0, 0,  0, 0,   0, 4'b0000, 6'b100000, 32'd1000, 32'd0);
    addVec(1, 4,  0, 200, 1, 4'b0000, 6'b100000, 32'd1000, 32'd0);
    addVec(1, 0,  1, 200, 0, 4'b0000, 6'b001010, 32'd1000, 32'd0);
    addVec(0, 0,  0, 0,   0, 4'b0000, 6'b101000, 32'd1000, 32'd0);
    addVec(1, 4,  0, 200, 0, 4'b0000, 6'b010100, 32'd1000, 32'd0);
    addVec(0, 0,  0, 0,   0, 4'b1000, 6'b010100, 32'd1000, 32'd0);
    addVec(0, 0,  0, 0,   0, 4'b1100, 6'b010100, 32'd900,  32'd1);
    addVec(0, 0,  0, 0,   0, 4'b1100, 6'b010100, 32'd900,  32'd1);
    addVec(0, 0,  0, 0,   0, 4'b0100, 6'b010100, 32'd800,  32'd2);
    addVec(0, 0,  0, 0,   0, 4'b0110, 6'b010100, 32'd900,  32'd3);
    addVec(0, 0,  0, 0,   0, 4'b0010, 6'b000010, 32'd900,  32'd4);
    addVec(0, 0,  0, 0,   0, 4'b0010, 6'b100000, 32'd1000, 32'd4);
    addVec(0, 0,  0, 0,   0, 4'b0011, 6'b100000, 32'd1000, 32'd4);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].steps, vecs[i].dir, vecs[i].minDelay,
                    vecs[i].abortV, vecs[i].coil);
      checkState($sformatf("vec%0d", i), vecs[i].expFlags, vecs[i].expDelay, vecs[i].expPos);
    end

    // 20-step CCW move with cruise at 700
    doReset();
    applyStimulus(1, 20, 1, 700, 0, 4'b0000);
    checkState("A/start", 6'b011100, 32'd1000, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, halfSeq[0]);
    checkState("A/energize", 6'b011100, 32'd1000, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 0, 0, 0, 0, advanceCoil());
      if (k < 20) checkState($sformatf("A/step%0d", k), 6'b011100, expA(k), 32'(-k));
      else        checkState("A/end", 6'b001010, 32'd1000, 32'(-20));
    end
    applyStimulus(0, 0, 0, 0, 0, halfSeq[seqIdx]);
    checkState("A/idle", 6'b101000, 32'd1000, 32'(-20));

    // abort without a coincident step, then abort coinciding with a step
    doReset();
    applyStimulus(1, 20, 0, 200, 0, 4'b0000);
    checkState("B/start", 6'b010100, 32'd1000, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, halfSeq[0]);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, advanceCoil());
      checkState($sformatf("B/step%0d", k), 6'b010100, 32'(1000 - 100 * k), 32'(k));
    end
    applyStimulus(0, 0, 0, 0, 1, halfSeq[seqIdx]);
    checkState("B/abort", 6'b000011, 32'd500, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, advanceCoil());
    checkState("B/idleCoil", 6'b100000, 32'd1000, 32'd5);
    applyStimulus(1, 20, 0, 200, 0, halfSeq[seqIdx]);
    checkState("B2/start", 6'b010100, 32'd1000, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, advanceCoil());
      checkState($sformatf("B2/step%0d", k), 6'b010100, 32'(1000 - 100 * k), 32'(5 + k));
    end
    applyStimulus(0, 0, 0, 0, 1, advanceCoil());
    checkState("B2/abortStep", 6'b000011, 32'd500, 32'd11);
    applyStimulus(0, 0, 0, 0, 0, halfSeq[seqIdx]);
    checkState("B2/idle", 6'b100000, 32'd1000, 32'd11);

    // asynchronous reset in the middle of a move
    applyStimulus(1, 10, 1, 200, 0, halfSeq[seqIdx]);
    checkState("D/start", 6'b011100, 32'd1000, 32'd11);
    applyStimulus(0, 0, 0, 0, 0, advanceCoil());
    applyStimulus(0, 0, 0, 0, 0, advanceCoil());
    checkState("D/step2", 6'b011100, 32'd800, 32'd9);
    rst_n = 1'b0;
    #1;
    checkState("D/asyncReset", 6'b100000, 32'd1000, 32'd0);

    // min delay 0 clamps to 4; held command waits until after done
    doReset();
    applyStimulus(1, 30, 0, 0, 0, 4'b0000);
    checkState("C/start", 6'b010100, 32'd1000, 32'd0);
    applyStimulus(1, 30, 0, 0, 0, halfSeq[0]);
    checkState("C/energize", 6'b010100, 32'd1000, 32'd0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1, 30, 0, 0, 0, advanceCoil());
      if (k < 30) checkState($sformatf("C/step%0d", k), 6'b010100, expC(k), 32'(k));
      else        checkState("C/end", 6'b000010, 32'd1000, 32'd30);
    end
    applyStimulus(1, 30, 0, 0, 0, halfSeq[seqIdx]);
    checkState("C/idle", 6'b100000, 32'd1000, 32'd30);
    applyStimulus(1, 30, 0, 0, 0, halfSeq[seqIdx]);
    checkState("C/reaccept", 6'b010100, 32'd1000, 32'd30);
    applyStimulus(0, 0, 0, 0, 1, halfSeq[seqIdx]);
    checkState("C/abort", 6'b000011, 32'd1000, 32'd30);
    applyStimulus(0, 0, 0, 0, 0, halfSeq[seqIdx]);
    checkState("C/final", 6'b100000, 32'd1000, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
